// File: rtl/multi_context_pc.sv
// ----------------------------------------------------------------------------
// multi_context_pc
//
// Program counter for a multiprogrammed core. Context 0 is the kernel; contexts
// 1..NUM_CTX-1 are user programs, each confined to a REGION_SIZE-word region
// starting at base(c) = c*REGION_SIZE. A saved-PC table lets the kernel resume
// any context. Quantum expiry, yield and exit trap back to KERNEL_VEC.
//
// Optional feature macro: PC_BOUNDS_CHECK_EN
//   When defined, a user-context next address outside its region raises a
//   fault trap (cause 100) instead of being loaded. The kernel is never checked.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-low reset
//   stop                 freeze all state (quantum load still honoured)
//   defquantum           load quantum register from quantum_val (0 = off)
//   dispatch*            kernel request to enter a context (fresh or resume)
//   yield, exit          user requests to return to kernel
//   desvio, zero,        branch code and ALU flags
//   negativo
//   novoEnd              region-relative branch target
//   novoEndR             absolute branch target / yield next-context hint
//   endereco             current fetch address
//   enderecoSpc          PC saved at the last trap
//   ctx_atual            running context
//   next_ctx             scheduler hint for the kernel
//   trap_valid           one-cycle trap pulse
//   trap_cause           001 quantum, 010 yield, 011 exit, 100 fault
//
// Handshake: all requests are level-sampled on the rising edge; there is no
// ready. A dispatch is accepted only from the kernel with a legal context;
// otherwise it is dropped silently. All outputs are registered.
// ----------------------------------------------------------------------------
module multi_context_pc #(
    parameter int          ADDR_W      = 32,
    parameter int          NUM_CTX     = 4,
    parameter int          REGION_SIZE = 200,
    parameter int unsigned KERNEL_VEC  = 0,
    localparam int         CTX_W       = (NUM_CTX > 2) ? $clog2(NUM_CTX) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stop,
    input  logic              defquantum,
    input  logic [ADDR_W-1:0] quantum_val,
    input  logic              dispatch,
    input  logic [CTX_W-1:0]  dispatch_ctx,
    input  logic              dispatch_resume,
    input  logic [ADDR_W-1:0] dispatch_pc,
    input  logic              yield,
    input  logic              exit,
    input  logic [2:0]        desvio,
    input  logic              zero,
    input  logic              negativo,
    input  logic [ADDR_W-1:0] novoEnd,
    input  logic [ADDR_W-1:0] novoEndR,
    output logic [ADDR_W-1:0] endereco,
    output logic [ADDR_W-1:0] enderecoSpc,
    output logic [CTX_W-1:0]  ctx_atual,
    output logic [CTX_W-1:0]  next_ctx,
    output logic              trap_valid,
    output logic [2:0]        trap_cause
);

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'b000,
        CAUSE_QUANTUM = 3'b001,
        CAUSE_YIELD   = 3'b010,
        CAUSE_EXIT    = 3'b011,
        CAUSE_FAULT   = 3'b100
    } cause_e;

    localparam logic [ADDR_W-1:0] KVEC   = ADDR_W'(KERNEL_VEC);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    function automatic logic [ADDR_W-1:0] ctx_base(input logic [CTX_W-1:0] c);
        return ADDR_W'(c) * ADDR_W'(REGION_SIZE);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] endereco_q,    endereco_d;
    logic [ADDR_W-1:0] spc_q,         spc_d;
    logic [CTX_W-1:0]  ctx_q,         ctx_d;
    logic [CTX_W-1:0]  next_ctx_q,    next_ctx_d;
    logic              trap_valid_q,  trap_valid_d;
    cause_e            cause_q,       cause_d;
    logic [ADDR_W-1:0] count_q,       count_d;
    logic [ADDR_W-1:0] quantum_q;
    logic [ADDR_W-1:0] saved_pc_q [NUM_CTX];

    // saved-PC table write port (always targets the running context)
    logic              sp_we;
    logic [ADDR_W-1:0] sp_val;

    // ------------------------------------------------------------------
    // Next-address computation
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] base_cur;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] rel_tgt;
    logic [ADDR_W-1:0] branch_pc;

    always_comb begin
        base_cur = ctx_base(ctx_q);
        seq_pc   = endereco_q + ONE;
        rel_tgt  = novoEnd + base_cur;
        unique case (desvio)
            3'b001:  branch_pc = rel_tgt;
            3'b010:  branch_pc = zero              ? rel_tgt : seq_pc;
            3'b100:  branch_pc = !zero             ? rel_tgt : seq_pc;
            3'b101:  branch_pc = negativo          ? rel_tgt : seq_pc;
            3'b110:  branch_pc = (negativo | zero) ? rel_tgt : seq_pc;
            3'b011:  branch_pc = novoEndR;
            default: branch_pc = seq_pc;          // 000 and 111
        endcase
    end

    // ------------------------------------------------------------------
    // Trap and dispatch qualification
    // ------------------------------------------------------------------
    logic in_user;
    logic seq_slot;
    logic trap_exit, trap_yield, trap_quantum, trap_fault, trap_any;
    logic disp_ok;

    always_comb begin
        in_user      = (ctx_q != '0);
        // voluntary and quantum traps only on plain sequential cycles
        seq_slot     = in_user && (desvio == 3'b000);
        trap_exit    = seq_slot && exit;
        trap_yield   = seq_slot && yield;
        trap_quantum = seq_slot && (quantum_q != '0) && (count_q >= quantum_q);
`ifdef PC_BOUNDS_CHECK_EN
        // offset arithmetic handles regions that straddle the 2^ADDR_W wrap
        trap_fault   = in_user &&
                       ((branch_pc - base_cur) >= ADDR_W'(REGION_SIZE));
`else
        trap_fault   = 1'b0;
`endif
        trap_any     = trap_exit || trap_yield || trap_quantum || trap_fault;
        disp_ok      = dispatch && !in_user && (int'(dispatch_ctx) < NUM_CTX);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        endereco_d   = endereco_q;
        spc_d        = spc_q;
        ctx_d        = ctx_q;
        next_ctx_d   = next_ctx_q;
        trap_valid_d = 1'b0;   // pulse; also dropped while stopped
        cause_d      = cause_q;
        count_d      = count_q;
        sp_we        = 1'b0;
        sp_val       = endereco_q;

        if (stop) begin
            // hold everything
        end else if (disp_ok) begin
            ctx_d      = dispatch_ctx;
            count_d    = '0;
            endereco_d = dispatch_resume ? saved_pc_q[dispatch_ctx]
                                         : dispatch_pc + ctx_base(dispatch_ctx);
        end else if (trap_any) begin
            // exit and fault record the current PC, others the return PC
            if (trap_exit) begin
                cause_d = CAUSE_EXIT;
                sp_val  = endereco_q;
            end else if (trap_yield) begin
                cause_d = CAUSE_YIELD;
                sp_val  = seq_pc;
            end else if (trap_quantum) begin
                cause_d = CAUSE_QUANTUM;
                sp_val  = seq_pc;
            end else begin
                cause_d = CAUSE_FAULT;
                sp_val  = endereco_q;
            end
            sp_we        = 1'b1;
            spc_d        = sp_val;
            endereco_d   = KVEC;
            ctx_d        = '0;
            count_d      = '0;
            trap_valid_d = 1'b1;
            if (trap_yield && !trap_exit) begin
                next_ctx_d = novoEndR[CTX_W-1:0];
            end else if (int'(ctx_q) >= NUM_CTX - 1) begin
                next_ctx_d = CTX_W'(1);
            end else begin
                next_ctx_d = ctx_q + CTX_W'(1);
            end
        end else begin
            endereco_d = branch_pc;
            if (in_user && (count_q != CNT_MAX)) begin
                count_d = count_q + ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            endereco_q   <= KVEC;
            spc_q        <= '0;
            ctx_q        <= '0;
            next_ctx_q   <= CTX_W'(1);
            trap_valid_q <= 1'b0;
            cause_q      <= CAUSE_NONE;
            count_q      <= '0;
        end else begin
            endereco_q   <= endereco_d;
            spc_q        <= spc_d;
            ctx_q        <= ctx_d;
            next_ctx_q   <= next_ctx_d;
            trap_valid_q <= trap_valid_d;
            cause_q      <= cause_d;
            count_q      <= count_d;
        end
    end

    // quantum register ignores stop
    always_ff @(posedge clock) begin
        if (!reset) begin
            quantum_q <= '0;
        end else if (defquantum) begin
            quantum_q <= quantum_val;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                saved_pc_q[i] <= ctx_base(CTX_W'(i));
            end
        end else if (sp_we) begin
            saved_pc_q[ctx_q] <= sp_val;
        end
    end

    assign endereco    = endereco_q;
    assign enderecoSpc = spc_q;
    assign ctx_atual   = ctx_q;
    assign next_ctx    = next_ctx_q;
    assign trap_valid  = trap_valid_q;
    assign trap_cause  = cause_q;

endmodule

// File: tb/tb_multi_context_pc.sv
// ----------------------------------------------------------------------------
// tb_multi_context_pc
//
// Directed bench for multi_context_pc with default parameters (ADDR_W=32,
// NUM_CTX=4, REGION_SIZE=200, KERNEL_VEC=0). Inputs change #1 after a rising
// edge; outputs are checked #1 after the following rising edge.
// ----------------------------------------------------------------------------
module tb_multi_context_pc;

    logic        clock = 1'b0;
    logic        reset;
    logic        stop;
    logic        defquantum;
    logic [31:0] quantum_val;
    logic        dispatch;
    logic [1:0]  dispatch_ctx;
    logic        dispatch_resume;
    logic [31:0] dispatch_pc;
    logic        yield;
    logic        exit;
    logic [2:0]  desvio;
    logic        zero;
    logic        negativo;
    logic [31:0] novoEnd;
    logic [31:0] novoEndR;
    logic [31:0] endereco;
    logic [31:0] enderecoSpc;
    logic [1:0]  ctx_atual;
    logic [1:0]  next_ctx;
    logic        trap_valid;
    logic [2:0]  trap_cause;

    int n_cmp = 0;
    int n_err = 0;

    multi_context_pc dut (
        .clock           (clock),
        .reset           (reset),
        .stop            (stop),
        .defquantum      (defquantum),
        .quantum_val     (quantum_val),
        .dispatch        (dispatch),
        .dispatch_ctx    (dispatch_ctx),
        .dispatch_resume (dispatch_resume),
        .dispatch_pc     (dispatch_pc),
        .yield           (yield),
        .exit            (exit),
        .desvio          (desvio),
        .zero            (zero),
        .negativo        (negativo),
        .novoEnd         (novoEnd),
        .novoEndR        (novoEndR),
        .endereco        (endereco),
        .enderecoSpc     (enderecoSpc),
        .ctx_atual       (ctx_atual),
        .next_ctx        (next_ctx),
        .trap_valid      (trap_valid),
        .trap_cause      (trap_cause)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset = 1'b1; stop = 1'b0; defquantum = 1'b0; quantum_val = '0;
        dispatch = 1'b0; dispatch_ctx = '0; dispatch_resume = 1'b0;
        dispatch_pc = '0; yield = 1'b0; exit = 1'b0; desvio = 3'b000;
        zero = 1'b0; negativo = 1'b0; novoEnd = '0; novoEndR = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic do_dispatch(input int c, input int pc, input bit resume);
        dispatch = 1'b1; dispatch_ctx = 2'(c); dispatch_pc = 32'(pc);
        dispatch_resume = resume;
        tick();
        dispatch = 1'b0; dispatch_resume = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (endereco !== 32'd0) begin n_err++; $display("FAIL rst_addr got=%0d exp=0", endereco); end
        n_cmp++; if (ctx_atual !== 2'd0) begin n_err++; $display("FAIL rst_ctx got=%0d exp=0", ctx_atual); end
        n_cmp++; if (next_ctx !== 2'd1) begin n_err++; $display("FAIL rst_next got=%0d exp=1", next_ctx); end
        n_cmp++; if (trap_valid !== 1'b0) begin n_err++; $display("FAIL rst_tv got=%b exp=0", trap_valid); end
        n_cmp++; if (enderecoSpc !== 32'd0) begin n_err++; $display("FAIL rst_spc got=%0d exp=0", enderecoSpc); end
        n_cmp++; if (trap_cause !== 3'b000) begin n_err++; $display("FAIL rst_cause got=%b exp=000", trap_cause); end
        // kernel increments sequentially
        tick();
        n_cmp++; if (endereco !== 32'd1) begin n_err++; $display("FAIL kern_inc got=%0d exp=1", endereco); end
    endtask

    task automatic test_dispatch_branch();
        do_reset();
        do_dispatch(2, 5, 1'b0);
        n_cmp++; if (endereco !== 32'd405) begin n_err++; $display("FAIL disp_addr got=%0d exp=405", endereco); end
        n_cmp++; if (ctx_atual !== 2'd2) begin n_err++; $display("FAIL disp_ctx got=%0d exp=2", ctx_atual); end
        desvio = 3'b010; zero = 1'b1; novoEnd = 32'd20;
        tick();
        n_cmp++; if (endereco !== 32'd420) begin n_err++; $display("FAIL br_zero got=%0d exp=420", endereco); end
        // zero clear: 100 taken, 010 not
        desvio = 3'b010; zero = 1'b0;
        tick();
        n_cmp++; if (endereco !== 32'd421) begin n_err++; $display("FAIL br_nz_nt got=%0d exp=421", endereco); end
        desvio = 3'b100; novoEnd = 32'd30;
        tick();
        n_cmp++; if (endereco !== 32'd430) begin n_err++; $display("FAIL br_notzero got=%0d exp=430", endereco); end
        desvio = 3'b101; negativo = 1'b0; novoEnd = 32'd50;
        tick();
        n_cmp++; if (endereco !== 32'd431) begin n_err++; $display("FAIL br_neg_nt got=%0d exp=431", endereco); end
        desvio = 3'b110; negativo = 1'b1;
        tick();
        n_cmp++; if (endereco !== 32'd450) begin n_err++; $display("FAIL br_negzero got=%0d exp=450", endereco); end
        desvio = 3'b111;
        tick();
        n_cmp++; if (endereco !== 32'd451) begin n_err++; $display("FAIL br_111 got=%0d exp=451", endereco); end
        // dispatch from a user context is ignored
        desvio = 3'b000; negativo = 1'b0;
        dispatch = 1'b1; dispatch_ctx = 2'd1; dispatch_pc = 32'd0;
        tick();
        dispatch = 1'b0;
        n_cmp++; if (endereco !== 32'd452 || ctx_atual !== 2'd2) begin n_err++; $display("FAIL disp_ign got=%0d/%0d exp=452/2", endereco, ctx_atual); end
        desvio = 3'b011; novoEndR = 32'd7;
        tick();
`ifdef PC_BOUNDS_CHECK_EN
        n_cmp++; if (trap_cause !== 3'b100 || enderecoSpc !== 32'd452 || endereco !== 32'd0) begin n_err++; $display("FAIL br_abs_fault got=%b/%0d/%0d exp=100/452/0", trap_cause, enderecoSpc, endereco); end
`else
        n_cmp++; if (endereco !== 32'd7) begin n_err++; $display("FAIL br_abs got=%0d exp=7", endereco); end
`endif
    endtask

    task automatic test_quantum();
        do_reset();
        defquantum = 1'b1; quantum_val = 32'd3;
        do_dispatch(1, 0, 1'b0);
        defquantum = 1'b0;
        n_cmp++; if (endereco !== 32'd200) begin n_err++; $display("FAIL q_start got=%0d exp=200", endereco); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++; if (endereco !== 32'(200 + i) || trap_valid !== 1'b0) begin n_err++; $display("FAIL q_run%0d got=%0d/%b exp=%0d/0", i, endereco, trap_valid, 200 + i); end
        end
        tick();
        n_cmp++; if (trap_valid !== 1'b1) begin n_err++; $display("FAIL q_tv got=%b exp=1", trap_valid); end
        n_cmp++; if (trap_cause !== 3'b001) begin n_err++; $display("FAIL q_cause got=%b exp=001", trap_cause); end
        n_cmp++; if (enderecoSpc !== 32'd204) begin n_err++; $display("FAIL q_spc got=%0d exp=204", enderecoSpc); end
        n_cmp++; if (endereco !== 32'd0 || ctx_atual !== 2'd0) begin n_err++; $display("FAIL q_kvec got=%0d/%0d exp=0/0", endereco, ctx_atual); end
        n_cmp++; if (next_ctx !== 2'd2) begin n_err++; $display("FAIL q_next got=%0d exp=2", next_ctx); end
        do_dispatch(1, 0, 1'b1);
        n_cmp++; if (endereco !== 32'd204) begin n_err++; $display("FAIL q_resume got=%0d exp=204", endereco); end
        n_cmp++; if (trap_valid !== 1'b0 || trap_cause !== 3'b001) begin n_err++; $display("FAIL q_hold got=%b/%b exp=0/001", trap_valid, trap_cause); end
        // reset reinitialises the saved-PC table
        do_reset();
        n_cmp++; if (endereco !== 32'd0 || ctx_atual !== 2'd0) begin n_err++; $display("FAIL q_rst got=%0d/%0d exp=0/0", endereco, ctx_atual); end
        do_dispatch(1, 0, 1'b1);
        n_cmp++; if (endereco !== 32'd200) begin n_err++; $display("FAIL q_rst_tbl got=%0d exp=200", endereco); end
    endtask

    task automatic test_yield_exit();
        do_reset();
        yield = 1'b1; exit = 1'b1;
        tick();
        n_cmp++; if (endereco !== 32'd1 || trap_valid !== 1'b0) begin n_err++; $display("FAIL y_kernel got=%0d/%b exp=1/0", endereco, trap_valid); end
        yield = 1'b0; exit = 1'b0;
        do_dispatch(2, 10, 1'b0);
        n_cmp++; if (endereco !== 32'd410) begin n_err++; $display("FAIL y_start got=%0d exp=410", endereco); end
        yield = 1'b1; novoEndR = 32'd3;
        tick();
        yield = 1'b0;
        n_cmp++; if (trap_valid !== 1'b1 || trap_cause !== 3'b010) begin n_err++; $display("FAIL y_cause got=%b/%b exp=1/010", trap_valid, trap_cause); end
        n_cmp++; if (enderecoSpc !== 32'd411) begin n_err++; $display("FAIL y_spc got=%0d exp=411", enderecoSpc); end
        n_cmp++; if (next_ctx !== 2'd3) begin n_err++; $display("FAIL y_next got=%0d exp=3", next_ctx); end
        do_dispatch(1, 50, 1'b0);
        exit = 1'b1; yield = 1'b1;
        tick();
        yield = 1'b0;
        n_cmp++; if (trap_cause !== 3'b011 || enderecoSpc !== 32'd250) begin n_err++; $display("FAIL ex_cause got=%b/%0d exp=011/250", trap_cause, enderecoSpc); end
        n_cmp++; if (next_ctx !== 2'd2) begin n_err++; $display("FAIL ex_next got=%0d exp=2", next_ctx); end
        exit = 1'b0;
        do_dispatch(1, 0, 1'b1);
        n_cmp++; if (endereco !== 32'd250) begin n_err++; $display("FAIL ex_resume got=%0d exp=250", endereco); end
        exit = 1'b1; desvio = 3'b001; novoEnd = 32'd30;
        tick();
        n_cmp++; if (endereco !== 32'd230 || trap_valid !== 1'b0 || ctx_atual !== 2'd1) begin n_err++; $display("FAIL ex_branch got=%0d/%b/%0d exp=230/0/1", endereco, trap_valid, ctx_atual); end
        desvio = 3'b000;
        tick();
        exit = 1'b0;
        n_cmp++; if (trap_valid !== 1'b1 || enderecoSpc !== 32'd230) begin n_err++; $display("FAIL ex_plain got=%b/%0d exp=1/230", trap_valid, enderecoSpc); end
        // wrap of next_ctx from last context to 1
        do_dispatch(3, 0, 1'b0);
        n_cmp++; if (endereco !== 32'd600) begin n_err++; $display("FAIL w_start got=%0d exp=600", endereco); end
        exit = 1'b1;
        tick();
        exit = 1'b0;
        n_cmp++; if (next_ctx !== 2'd1 || trap_cause !== 3'b011) begin n_err++; $display("FAIL w_next got=%0d/%b exp=1/011", next_ctx, trap_cause); end
    endtask

    task automatic test_stop();
        do_reset();
        defquantum = 1'b1; quantum_val = 32'd3;
        do_dispatch(1, 27, 1'b0);
        defquantum = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (endereco !== 32'd230) begin n_err++; $display("FAIL s_pre got=%0d exp=230", endereco); end
        stop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (endereco !== 32'd230 || trap_valid !== 1'b0) begin n_err++; $display("FAIL s_hold%0d got=%0d/%b exp=230/0", i, endereco, trap_valid); end
        end
        stop = 1'b0;
        tick();
        n_cmp++; if (trap_valid !== 1'b1 || trap_cause !== 3'b001 || enderecoSpc !== 32'd231) begin n_err++; $display("FAIL s_trap got=%b/%b/%0d exp=1/001/231", trap_valid, trap_cause, enderecoSpc); end
        tick();
        n_cmp++; if (trap_valid !== 1'b0) begin n_err++; $display("FAIL s_pulse got=%b exp=0", trap_valid); end
    endtask

    task automatic test_bounds();
        do_reset();
        do_dispatch(1, 199, 1'b0);
        n_cmp++; if (endereco !== 32'd399) begin n_err++; $display("FAIL b_start got=%0d exp=399", endereco); end
        tick();
`ifdef PC_BOUNDS_CHECK_EN
        n_cmp++; if (trap_cause !== 3'b100 || enderecoSpc !== 32'd399 || endereco !== 32'd0) begin n_err++; $display("FAIL b_fault got=%b/%0d/%0d exp=100/399/0", trap_cause, enderecoSpc, endereco); end
`else
        n_cmp++; if (endereco !== 32'd400 || trap_valid !== 1'b0 || ctx_atual !== 2'd1) begin n_err++; $display("FAIL b_nocheck got=%0d/%b/%0d exp=400/0/1", endereco, trap_valid, ctx_atual); end
`endif
    endtask

    initial begin
        idle();
        test_reset();
        test_dispatch_branch();
        test_quantum();
        test_yield_exit();
        test_stop();
        test_bounds();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_context_pc.md
# multi_context_pc

Parametrised multi-context program counter for the multiprogrammed processor core. It holds the fetch address for a kernel context (context 0) and up to NUM_CTX-1 user contexts, each confined to its own fixed-size instruction region. A per-context saved-PC table lets the kernel resume any context directly. Quantum-based preemption, voluntary yield and program exit trap back to the kernel vector. The block feeds instruction memory and sits between the control unit (branch/dispatch requests) and the ALU flags.

## Interface
- ADDR_W, 32, address width
- NUM_CTX, 4, contexts including kernel (≥2); CTX_W = max(1, $clog2(NUM_CTX)) derived
- REGION_SIZE, 200, words per context; base(c) = c*REGION_SIZE
- KERNEL_VEC, 0, kernel trap entry address

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- stop  in  1  freeze all state except reset
- defquantum  in  1  load quantum register from quantum_val
- quantum_val  in  ADDR_W  quantum in instructions; 0 = no preemption
- dispatch  in  1  kernel dispatch request
- dispatch_ctx  in  CTX_W  target context
- dispatch_resume  in  1  1: resume from saved PC; 0: start at dispatch_pc
- dispatch_pc  in  ADDR_W  region-relative start address
- yield  in  1  user requests kernel; novoEndR[CTX_W-1:0] = requested next context
- exit  in  1  user program finished
- desvio  in  3  branch code
- zero, negativo  in  1  ALU flags
- novoEnd  in  ADDR_W  region-relative branch target
- novoEndR  in  ADDR_W  absolute target / yield hint
- endereco  out  ADDR_W  current fetch address
- enderecoSpc  out  ADDR_W  PC saved at last trap
- ctx_atual  out  CTX_W  running context
- next_ctx  out  CTX_W  scheduler hint for kernel
- trap_valid  out  1  one-cycle trap pulse
- trap_cause  out  3  001 quantum, 010 yield, 011 exit, 100 fault

## Operation
- Priority per edge: reset > stop > dispatch > trap > branch/increment.
- Reset (reset=0): endereco=KERNEL_VEC, ctx_atual=0, enderecoSpc=0, next_ctx=1, trap_valid=0, trap_cause=000, quantum=0, instr count=0, saved_pc[i]=base(i).
- defquantum honoured whenever not in reset, including during stop.
- Dispatch honoured only when ctx_atual==0 and dispatch_ctx<NUM_CTX; otherwise ignored. Sets ctx_atual=dispatch_ctx, count=0, endereco = saved_pc[ctx] if resume else dispatch_pc+base(ctx).
- Trap: only when ctx_atual≠0, desvio==000 and (exit | yield | count≥quantum with quantum≠0). Cause priority exit > yield > quantum. Saved value = endereco for exit, else endereco+1; written to saved_pc[ctx] and enderecoSpc. endereco←KERNEL_VEC, ctx_atual←0, count←0, trap_valid=1, trap_cause set.
- next_ctx on trap: yield → novoEndR[CTX_W-1:0]; otherwise ctx+1, wrapping from NUM_CTX-1 to 1 (never 0).
- yield/exit in kernel are ignored. Non-zero desvio with yield/exit: no trap, branch executes.
- Branch codes (b = base(ctx_atual); kernel b=0): 000 +1; 001 novoEnd+b; 010 zero?novoEnd+b:+1; 100 !zero?…; 101 negativo?…; 110 (negativo|zero)?…; 011 novoEndR absolute; 111 +1.
- Count increments by 1 on each non-stalled, non-trap user-context cycle. It saturates at all-ones.
- Arithmetic is modulo 2^ADDR_W.

## Timing
- All outputs are registered and change only on the rising edge following the causing inputs.
- trap_valid is high for exactly the cycle in which endereco first equals KERNEL_VEC. trap_cause and enderecoSpc hold until the next trap or reset.
- A dispatch takes effect in one cycle. The first user instruction address appears the edge after dispatch.
- A reset asserted mid-trap or mid-dispatch wins; the table is reinitialised.

## Configuration
- PC_BOUNDS_CHECK_EN defined: in user context, any computed next address outside [base, base+REGION_SIZE) traps with cause 100 instead of being loaded. This covers sequential overflow, relative targets and absolute targets. enderecoSpc = saved_pc = faulting endereco. Lowest trap priority. Kernel context is unchecked.
- Undefined: no check is made, and cause 100 never occurs.

## Test plan
- reset=0 for one edge → endereco=0, ctx_atual=0, next_ctx=1, trap_valid=0, enderecoSpc=0.
- Dispatch ctx 2, pc 5, resume=0 → endereco=405. Then desvio=010, zero=1, novoEnd=20 → 420. Then desvio=011, novoEndR=7 → 7.
- Quantum=3, dispatch ctx 1 pc 0 → 200, 201, 202, 203, then trap: cause 001, enderecoSpc=204, endereco=0, next_ctx=2. Dispatch resume ctx 1 → 204.
- ctx 2 at 410: yield=1, novoEndR=3, desvio=000 → cause 010, enderecoSpc=411, next_ctx=3. exit+yield together at 250 in ctx 1 → cause 011, saved 250. exit with desvio=001 → no trap, branch taken.
- stop held 5 cycles in ctx 1 at 230 with quantum expiry pending → endereco and count frozen, no trap_valid. Trap fires on the first edge after stop releases.
- With PC_BOUNDS_CHECK_EN: ctx 1 at 399, desvio=000 → cause 100, enderecoSpc=399, endereco=0. Without the macro → endereco=400.
